// File: rtl/filter_out_collector.sv
// Collects the valid-window outputs of a raster-order filter stream and writes them to consecutive memory addresses.
// Latency: 1 cycle from an accepted kept sample to wen. There is no backpressure: en gaps only stall the raster position.
module filter_out_collector #(
    parameter int WIDTH = 16,
    parameter int FN    = 3,
    parameter int AW    = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [10:0]             img_w,
    input  logic [10:0]             img_h,
    input  logic [1:0]              stride,
    input  logic [AW-1:0]           base_addr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din,
    output logic                    wen,
    output logic [AW-1:0]           waddr,
    output logic signed [WIDTH-1:0] wdata,
    output logic                    busy,
    output logic                    done,
    output logic [AW-1:0]           out_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // First raster row/column at which a full FN x FN window is available.
    localparam logic [10:0] EDGE = 11'(FN - 1);

    logic [1:0]    state;
    logic [10:0]   w_r;
    logic [10:0]   h_r;
    logic          s2_r;
    logic [AW-1:0] base_r;
    logic [10:0]   col;
    logic [10:0]   row;

    logic [10:0]   row_off;
    logic [10:0]   col_off;
    logic          row_ok;
    logic          col_ok;
    logic          keep;
    logic          last_col;
    logic          last_row;

    // With stride 2, only positions at even offsets from the first full window are kept.
    always_comb begin
        row_off  = row - EDGE;
        col_off  = col - EDGE;
        row_ok   = (row >= EDGE) && (!s2_r || !row_off[0]);
        col_ok   = (col >= EDGE) && (!s2_r || !col_off[0]);
        keep     = row_ok && col_ok;
        last_col = (col == w_r - 11'd1);
        last_row = (row == h_r - 11'd1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            w_r     <= '0;
            h_r     <= '0;
            s2_r    <= 1'b0;
            base_r  <= '0;
            col     <= '0;
            row     <= '0;
            out_cnt <= '0;
            wen     <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
        end else begin
            wen <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w_r     <= img_w;
                        h_r     <= img_h;
                        s2_r    <= (stride == 2'd2);
                        base_r  <= base_addr;
                        col     <= '0;
                        row     <= '0;
                        out_cnt <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        if (keep) begin
                            wen     <= 1'b1;
                            wdata   <= din;
                            waddr   <= base_r + out_cnt;
                            out_cnt <= out_cnt + AW'(1);
                        end
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                state <= S_DONE;
                            end else begin
                                row <= row + 11'd1;
                            end
                        end else begin
                            col <= col + 11'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_filter_out_collector.sv
// Bench for filter_out_collector: table-driven frames plus randomized frames against a queue-based model.
module tb_filter_out_collector;

    localparam int WIDTH = 16;
    localparam int FN    = 3;
    localparam int AW    = 16;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic                    start;
    logic [10:0]             img_w;
    logic [10:0]             img_h;
    logic [1:0]              stride;
    logic [AW-1:0]           base_addr;
    logic                    en;
    logic signed [WIDTH-1:0] din;
    logic                    wen;
    logic [AW-1:0]           waddr;
    logic signed [WIDTH-1:0] wdata;
    logic                    busy;
    logic                    done;
    logic [AW-1:0]           out_cnt;

    always #5 clk = ~clk;

    filter_out_collector #(.WIDTH(WIDTH), .FN(FN), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .img_w(img_w), .img_h(img_h),
        .stride(stride), .base_addr(base_addr), .en(en), .din(din),
        .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .out_cnt(out_cnt)
    );

    typedef struct {
        int w;
        int h;
        int s;
        int base;
        int gap;
        bit raster;
        int exp_n;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
    } wr_t;

    vec_t tbl[8];
    wr_t  got[$];
    wr_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   d034[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    int   d035[9] = '{16, 18, 20, 30, 32, 34, 44, 46, 48};

    always @(negedge clk) if (wen) got.push_back({waddr, wdata});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic run_frame(input vec_t v, input bit poke_start);
        logic [WIDTH-1:0] px[$];
        wr_t e;
        int n, es, k, gaps, r, c;
        n  = v.w * v.h;
        es = (v.s == 2) ? 2 : 1;
        got.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) px.push_back(v.raster ? WIDTH'(i) : WIDTH'($urandom));
        k = 0;
        for (int i = 0; i < n; i++) begin
            r = i / v.w;
            c = i % v.w;
            if (r >= FN - 1 && c >= FN - 1 && (r - (FN - 1)) % es == 0 && (c - (FN - 1)) % es == 0) begin
                e.a = AW'(v.base + k);
                e.d = px[i];
                exp_q.push_back(e);
                k++;
            end
        end
        img_w = 11'(v.w); img_h = 11'(v.h); stride = 2'(v.s); base_addr = AW'(v.base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble the frame inputs: the DUT must use only the values sampled at start.
        img_w = 11'($urandom); img_h = 11'($urandom); stride = 2'($urandom); base_addr = AW'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            gaps = (v.gap > 0) ? $urandom_range(0, v.gap) : 0;
            repeat (gaps) begin
                @(negedge clk);
                if (busy !== 1'b1) chk("busy_in_gap", 32'(busy), 32'd1);
            end
            en = 1'b1;
            din = px[i];
            if (poke_start && i == 7) start = 1'b1;
            @(negedge clk);
            en = 1'b0;
            start = 1'b0;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_cleared", 32'(done), 32'd0);
        chk("out_cnt", 32'(out_cnt), 32'(v.exp_n));
        chk("write_count", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("waddr[%0d]", i), 32'(got[i].a), 32'(exp_q[i].a));
            chk($sformatf("wdata[%0d]", i), 32'(got[i].d), 32'(exp_q[i].d));
        end
    endtask

    task automatic chk_data(input string name, input int ref_d[9]);
        for (int i = 0; i < 9 && i < got.size(); i++)
            chk($sformatf("%s[%0d]", name, i), 32'(got[i].d), 32'(ref_d[i]));
    endtask

    initial begin
        vec_t v;
        int es;
        tbl[0] = '{w: 5, h: 5, s: 1, base: 'h100,  gap: 0, raster: 1, exp_n: 9};
        tbl[1] = '{w: 7, h: 7, s: 2, base: 'h40,   gap: 0, raster: 1, exp_n: 9};
        tbl[2] = '{w: 5, h: 5, s: 1, base: 'h100,  gap: 5, raster: 1, exp_n: 9};
        tbl[3] = '{w: 5, h: 5, s: 1, base: 'hFFFE, gap: 0, raster: 1, exp_n: 9};
        tbl[4] = '{w: 6, h: 4, s: 1, base: 'h200,  gap: 2, raster: 0, exp_n: 8};
        tbl[5] = '{w: 3, h: 3, s: 2, base: 'h10,   gap: 1, raster: 0, exp_n: 1};
        tbl[6] = '{w: 8, h: 5, s: 2, base: 'h300,  gap: 0, raster: 0, exp_n: 6};
        tbl[7] = '{w: 4, h: 9, s: 3, base: 'h400,  gap: 1, raster: 0, exp_n: 14};

        resetn = 1'b0; start = 1'b0; en = 1'b0; din = '0;
        img_w = '0; img_h = '0; stride = '0; base_addr = '0;
        #3;
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            run_frame(tbl[t], t == 4);
            if (t == 0 || t == 2 || t == 3) chk_data($sformatf("raster5_t%0d", t), d034);
            if (t == 1) chk_data("raster7_s2", d035);
        end

        // en while idle must not write or move the counters.
        got.delete();
        repeat (5) begin
            en = 1'b1; din = WIDTH'($urandom);
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        chk("idle_en_writes", 32'(got.size()), 32'd0);
        chk("idle_en_out_cnt", 32'(out_cnt), 32'(tbl[7].exp_n));
        chk("idle_en_busy", 32'(busy), 32'd0);

        // Asynchronous reset after 10 accepted pixels of a frame.
        img_w = 11'd5; img_h = 11'd5; stride = 2'd1; base_addr = AW'('h100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en = 1'b1; din = WIDTH'(i);
            @(negedge clk);
        end
        en = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_waddr", 32'(waddr), 32'd0);
        chk("arst_wdata", 32'(wdata), 32'd0);
        chk("arst_out_cnt", 32'(out_cnt), 32'd0);
        chk("arst_wen", 32'(wen), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        got.delete();
        repeat (15) begin
            en = 1'b1; din = WIDTH'($urandom);
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        chk("post_rst_no_writes", 32'(got.size()), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        run_frame(tbl[0], 1'b1);
        chk_data("post_rst_frame", d034);

        // Randomized frames.
        for (int t = 0; t < 6; t++) begin
            v.w = $urandom_range(FN, 12);
            v.h = $urandom_range(FN, 10);
            v.s = $urandom_range(0, 3);
            v.base = $urandom_range(0, 'hFFFF);
            v.gap = $urandom_range(0, 3);
            v.raster = 1'b0;
            es = (v.s == 2) ? 2 : 1;
            v.exp_n = ((v.w - FN) / es + 1) * ((v.h - FN) / es + 1);
            run_frame(v, t[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_out_collector.md
FILTER_OUT_COLLECTOR -- requirements
Module: filter_out_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width of the filter output stream and the write data.
REQ-002 SHALL have parameter FN, default 3: filter window size in pixels per side, legal range 1..7.
REQ-003 SHALL have parameter AW, default 16: width of the destination memory address.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that begins collection of one frame.
REQ-007 SHALL have port img_w, input, 11: input frame width in pixels, legal range FN..2047.
REQ-008 SHALL have port img_h, input, 11: input frame height in pixels, legal range FN..2047.
REQ-009 SHALL have port stride, input, 2: window stride; 1 or 2 are legal, and 0 or 3 are treated as 1.
REQ-010 SHALL have port base_addr, input, AW: first write address of the output map.
REQ-011 SHALL have port en, input, 1: din is valid this cycle; one raster-order pixel position per asserted cycle.
REQ-012 SHALL have port din, input, WIDTH, signed: filter output sample for the current raster position.
REQ-013 SHALL have port wen, output, 1: write strobe to the destination memory.
REQ-014 SHALL have port waddr, output, AW: write address.
REQ-015 SHALL have port wdata, output, WIDTH, signed: write data.
REQ-016 SHALL have port busy, output, 1: high while state is RUN.
REQ-017 SHALL have port done, output, 1: one-cycle pulse when the frame is complete.
REQ-018 SHALL have port out_cnt, output, AW: number of samples written in the current or last frame.

Function
REQ-019 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-020 SHALL sample img_w, img_h, stride and base_addr into internal registers on start in IDLE, clear col, row and out_cnt, and move to RUN.
REQ-021 SHALL ignore start in RUN and in DONE, and SHALL ignore en in IDLE and in DONE.
REQ-022 SHALL, in RUN, advance col on each en cycle; at col == w-1, col SHALL wrap to 0 and row SHALL increment.
REQ-023 SHALL treat a position as kept when all of these hold: row >= FN-1, col >= FN-1, (row-(FN-1)) mod stride == 0, and (col-(FN-1)) mod stride == 0.
REQ-024 SHALL, for a kept position, register wen=1, wdata=din and waddr=base+out_cnt on the next edge (latency 1 cycle), and SHALL increment out_cnt in the same edge.
REQ-025 SHALL drive wen=0 in every other cycle, and SHALL hold waddr and wdata at their last values.
REQ-026 SHALL, when en is accepted at row == h-1 and col == w-1, move to DONE in that edge; that final pixel's write, if kept, SHALL still issue.
REQ-027 SHALL stay in DONE for exactly 1 cycle with done=1, then return to IDLE; out_cnt SHALL hold until the next start.
REQ-028 SHALL write exactly ((w-FN)/stride+1)*((h-FN)/stride+1) samples per frame, using integer division.
REQ-029 SHALL let waddr wrap modulo 2^AW with no error flag.
REQ-030 SHALL accept en gaps of any length in RUN without changing state.
REQ-031 SHALL accept back-to-back frames: a start in the cycle after done begins a new frame.

Reset
REQ-032 SHALL, while resetn=0, force state=IDLE, col=0, row=0, out_cnt=0, wen=0, waddr=0, wdata=0, busy=0 and done=0, immediately and independent of clk.
REQ-033 SHALL, when reset is asserted mid-frame, abandon the frame with no further writes; a new frame SHALL require a fresh start.

Verification
REQ-034 SHALL cover: FN=3, w=h=5, stride=1, din=raster index 0..24 -> 9 writes at base..base+8 with data 12,13,14,17,18,19,22,23,24; done 1 cycle after the last en; out_cnt=9.
REQ-035 SHALL cover: FN=3, w=h=7, stride=2 -> 9 writes with data 16,18,20,30,32,34,44,46,48.
REQ-036 SHALL cover: the REQ-034 stream with random en gaps of 0..5 cycles -> identical write sequence; busy stays high throughout.
REQ-037 SHALL cover: resetn pulsed low after 10 en cycles -> all outputs 0 asynchronously; a later start with a full frame produces the full REQ-034 result.
REQ-038 SHALL cover: start asserted in RUN, and en asserted in IDLE -> no effect on counters or writes; base_addr=0xFFFE with 9 writes -> waddr wraps 0xFFFE, 0xFFFF, 0x0000, ..., 0x0006.
